display_scan_mux: RTL

- Downstream stage of the hex-to-7-segment decode path.
- Latches a 16-bit value and time-multiplexes its four hex nibbles onto one shared active-low segment bus.
- Drives four active-low digit anodes, with a per-digit refresh divider, an optional anti-ghosting guard cycle and optional leading-zero blanking.
- Its outputs go directly to the board's 4-digit common-anode display.

---
 rtl/display_pkg.sv | 22 ++
 rtl/display_scan_mux_if.sv | 24 ++
 rtl/seg7_decode.sv | 11 +
 rtl/display_scan_mux.sv | 111 +++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit scanned 7-segment display path.
package display_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [1:0] digit_idx_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

    localparam seg7_t          SEG_OFF = 7'b1111111;
    localparam logic [3:0]     AN_OFF  = 4'b1111;

    // Active-low abcdefg patterns for hex digits 0..F (seg[6]=a ... seg[0]=g).
    localparam seg7_t SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/display_scan_mux_if.sv
// Control/value inputs and pin outputs of the display scan multiplexer.
interface display_scan_mux_if;
    import display_pkg::*;

    logic                 enable;
    logic                 load;
    logic [VALUE_W-1:0]   bin_in;
    logic                 blank_lz;
    seg7_t                seg;
    logic [3:0]           an;

    // Driver side (the logic feeding the display).
    modport master (
        output enable, load, bin_in, blank_lz,
        input  seg, an
    );

    // Display multiplexer side.
    modport slave (
        input  enable, load, bin_in, blank_lz,
        output seg, an
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg7_t      seg_o_c
);

    assign seg_o_c = SEG_LUT[nib_i];

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes a latched 16-bit value onto a 4-digit common-anode display.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 25000,
    parameter bit          GUARD_EN    = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    display_scan_mux_if.slave  bus
);

    localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // A single-cycle digit period would leave no lit cycle after the guard.
    if (REFRESH_DIV < 2 || REFRESH_DIV > 32'd1048576) begin : g_bad_div
        $error("display_scan_mux: REFRESH_DIV must be in 2..2^20");
    end

    logic [CNT_W-1:0]   div_q,   div_d;
    digit_idx_t         idx_q,   idx_d;
    logic [VALUE_W-1:0] value_q, value_d;
    seg7_t              seg_q,   seg_d;
    logic [3:0]         an_q,    an_d;

    logic [3:0]         nibble_c;
    logic               blank_c;
    seg7_t              dec_seg_c;

    // State and pin registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            idx_q   <= '0;
            value_q <= '0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    // Value capture and refresh divider / digit scan advance.
    always_comb begin
        div_d   = div_q;
        idx_d   = idx_q;
        value_d = value_q;
        if (bus.load) begin
            value_d = bus.bin_in;
        end
        if (!bus.enable) begin
            div_d = '0;
            idx_d = '0;
        end else if (div_q == CNT_LAST) begin
            div_d = '0;
            idx_d = idx_q + digit_idx_t'(1);
        end else begin
            div_d = div_q + CNT_W'(1);
        end
    end

    // Select the current digit's nibble and decide leading-zero blanking.
    always_comb begin
        nibble_c = value_q[3:0];
        blank_c  = 1'b0;
        case (idx_q)
            2'd0: nibble_c = value_q[3:0];
            2'd1: begin
                nibble_c = value_q[7:4];
                blank_c  = bus.blank_lz && (value_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_c = value_q[11:8];
                blank_c  = bus.blank_lz && (value_q[15:8] == 8'h00);
            end
            default: begin
                nibble_c = value_q[15:12];
                blank_c  = bus.blank_lz && (value_q[15:12] == 4'h0);
            end
        endcase
    end

    seg7_decode u_dec (
        .nib_i   (nibble_c),
        .seg_o_c (dec_seg_c)
    );

    // Next pin values: dark when disabled, in the guard cycle, or blanked.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (bus.enable && !(GUARD_EN && (div_q == '0)) && !blank_c) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg_c;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

    // Never drive two digits at once.
    a_one_anode: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~an_q))
        else $error("display_scan_mux: more than one anode active");

endmodule
